// File: rtl/proc_pkg.sv
// Shared definitions for the processor datapath: default word width and a
// behavioural rotate-right helper usable by RTL and by benches alike.
package proc_pkg;

  localparam int DATA_W = 8;

  // Reference rotate right: result[k] = word[(k + amt) mod DATA_W].
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] word,
                                             input int unsigned       amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {word, word};
    return dbl[(amt % DATA_W) +: DATA_W];
  endfunction

endpackage

// File: rtl/barrel_rotator.sv
// Combinational log2(N)-stage rotate-right network; stage s rotates by 2^s
// when the matching bit of sel_i is set.
module barrel_rotator #(
  parameter  int data_size = 8,
  localparam int SEL_W     = $clog2(data_size)
) (
  input  logic [data_size-1:0] src_i,
  input  logic [SEL_W-1:0]     sel_i,
  output logic [data_size-1:0] rot_o
);

  logic [data_size-1:0] stage [0:SEL_W];

  assign stage[0] = src_i;

  for (genvar s = 0; s < SEL_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    // Low SH bits leave the LSB end and re-enter at the MSB end.
    assign stage[s+1] = sel_i[s] ? {stage[s][SH-1:0], stage[s][data_size-1:SH]}
                                 : stage[s];
  end

  assign rot_o = stage[SEL_W];

endmodule

// File: rtl/barrel.sv
// Registered right-rotate barrel shifter; each edge rotates either fresh
// data_in or the fed-back data_out, so rotations can be chained.
module barrel
  import proc_pkg::*;
#(
  parameter  int data_size = DATA_W,
  localparam int SEL_W     = $clog2(data_size)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 Load,
  input  logic [data_size-1:0] data_in,
  output logic [data_size-1:0] data_out
);

  logic [data_size-1:0] src;
  logic [data_size-1:0] data_d;
  logic [data_size-1:0] data_q;

  assign src = Load ? data_in : data_q;

  barrel_rotator #(
    .data_size(data_size)
  ) u_rotator (
    .src_i(src),
    .sel_i(sel),
    .rot_o(data_d)
  );

  // No enable: the result register updates on every edge out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_barrel.sv
// Scoreboard bench for barrel: the driver pushes expected words at each
// edge, an independent monitor pops and compares on the falling edge.
module tb_barrel;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sel = '0;
  logic       Load = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  logic [7:0] expQ [$];
  string      tagQ [$];
  logic [7:0] modelOut = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  barrel #(
    .data_size(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .Load(Load),
    .data_in(data_in),
    .data_out(data_out)
  );

  // Rotate right expressed arithmetically: low part moves up, high part down.
  function automatic logic [7:0] refRot(input logic [7:0] x, input int s);
    int v;
    int lowPart;
    v = int'(x);
    lowPart = v % (1 << s);
    return 8'((v / (1 << s)) + lowPart * (1 << (8 - s)));
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] exp);
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("[TB] FAIL %s: data_out=%h expected=%h", tag, data_out, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(tagQ.pop_front(), expQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic ld, input logic [7:0] din,
                               input logic [2:0] s, input string tag);
    Load = ld;
    data_in = din;
    sel = s;
    @(posedge clk);
    modelOut = refRot(ld ? din : modelOut, int'(s));
    expQ.push_back(modelOut);
    tagQ.push_back(tag);
    @(negedge clk);
  endtask

  task automatic applyKnown(input logic ld, input logic [7:0] din,
                            input logic [2:0] s, input logic [7:0] exp,
                            input string tag);
    Load = ld;
    data_in = din;
    sel = s;
    @(posedge clk);
    modelOut = exp;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;

    // Reset held low with live load data: output must stay cleared.
    Load = 1'b1;
    data_in = 8'hFF;
    sel = 3'd0;
    #1 checkOutput("reset_pre_edge", 8'h00);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_hold", 8'h00);
    end
    reset = 1'b1;
    modelOut = 8'h00;

    applyKnown(1'b1, 8'hA5, 3'd0, 8'hA5, "load_sel0");
    applyKnown(1'b1, 8'hA5, 3'd3, 8'hB4, "load_sel3");
    applyKnown(1'b1, 8'h81, 3'd7, 8'h03, "load_sel7_wrap");

    applyKnown(1'b1, 8'h01, 3'd0, 8'h01, "recirc_load");
    applyKnown(1'b0, 8'hFF, 3'd1, 8'h80, "recirc_1");
    applyKnown(1'b0, 8'hFF, 3'd1, 8'h40, "recirc_2");
    applyKnown(1'b0, 8'hFF, 3'd1, 8'h20, "recirc_3");
    applyKnown(1'b0, 8'hFF, 3'd0, 8'h20, "recirc_hold");

    // Asynchronous clear between edges, observed before the next rising edge.
    #2 reset = 1'b0;
    #1 checkOutput("async_clear", 8'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("async_hold", 8'h00);
    reset = 1'b1;
    modelOut = 8'h00;
    applyKnown(1'b1, 8'h5A, 3'd4, 8'hA5, "post_reset_load");

    for (int t = 0; t < 3; t++) begin
      d = 8'($urandom);
      for (int s = 0; s < 8; s++) begin
        applyStimulus(1'b1, d, 3'(s), "sweep");
        applyStimulus(1'b1, d, 3'(s), "sweep_hold");
      end
    end

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    3'($urandom_range(0, 7)), "random_mix");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
